// File: rtl/seq_alu_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic, iterative shifts, registered compare flags.
// Valid/ready on both sides; one operation in flight, results held in DONE until consumed.
module seq_alu_exec #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            lt,
    output logic            ltu,
    output logic            busy
);

    localparam logic [3:0] ALU_ADD          = 4'b0000;
    localparam logic [3:0] ALU_LSHIFT_LEFT  = 4'b0001;
    localparam logic [3:0] ALU_XOR          = 4'b0100;
    localparam logic [3:0] ALU_LSHIFT_RIGHT = 4'b0101;
    localparam logic [3:0] ALU_OR           = 4'b0110;
    localparam logic [3:0] ALU_AND          = 4'b0111;
    localparam logic [3:0] ALU_SUB          = 4'b1000;
    localparam logic [3:0] ALU_ASHIFT_RIGHT = 4'b1101;

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e          r_state, w_state_nxt;
    logic [3:0]      r_ctrl, w_ctrl_nxt;
    logic [XLEN-1:0] r_work, w_work_nxt;
    logic [4:0]      r_cnt, w_cnt_nxt;
    logic [XLEN-1:0] r_result, w_result_nxt;
    logic            r_zero, w_zero_nxt;
    logic            r_lt, w_lt_nxt;
    logic            r_ltu, w_ltu_nxt;

    logic            w_is_shift;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [4:0]      w_step;
    logic [XLEN-1:0] w_shifted;

    assign w_shamt    = op_b[4:0];
    assign w_is_shift = (alu_ctrl == ALU_LSHIFT_LEFT) || (alu_ctrl == ALU_LSHIFT_RIGHT) ||
                        (alu_ctrl == ALU_ASHIFT_RIGHT);

    // Shift codes yield op_a here so a zero shift amount completes like any single-cycle op.
    always_comb begin
        w_alu = '0;
        case (alu_ctrl)
            ALU_ADD:          w_alu = op_a + op_b;
            ALU_SUB:          w_alu = op_a - op_b;
            ALU_XOR:          w_alu = op_a ^ op_b;
            ALU_OR:           w_alu = op_a | op_b;
            ALU_AND:          w_alu = op_a & op_b;
            ALU_LSHIFT_LEFT,
            ALU_LSHIFT_RIGHT,
            ALU_ASHIFT_RIGHT: w_alu = op_a;
            default:          w_alu = '0;
        endcase
    end

    assign w_step = (r_cnt < STEP) ? r_cnt : STEP;

    always_comb begin
        w_shifted = r_work;
        case (r_ctrl)
            ALU_LSHIFT_LEFT:  w_shifted = r_work << w_step;
            ALU_LSHIFT_RIGHT: w_shifted = r_work >> w_step;
            ALU_ASHIFT_RIGHT: w_shifted = $unsigned($signed(r_work) >>> w_step);
            default:          w_shifted = r_work;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ctrl_nxt   = r_ctrl;
        w_work_nxt   = r_work;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_zero_nxt   = r_zero;
        w_lt_nxt     = r_lt;
        w_ltu_nxt    = r_ltu;
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_ctrl_nxt = alu_ctrl;
                    w_lt_nxt   = $signed(op_a) < $signed(op_b);
                    w_ltu_nxt  = op_a < op_b;
                    if (w_is_shift && (w_shamt != 5'd0)) begin
                        w_work_nxt  = op_a;
                        w_cnt_nxt   = w_shamt;
                        w_state_nxt = StShift;
                    end else begin
                        w_result_nxt = w_alu;
                        w_zero_nxt   = (w_alu == '0);
                        w_state_nxt  = StDone;
                    end
                end
            end
            StShift: begin
                w_work_nxt = w_shifted;
                w_cnt_nxt  = r_cnt - w_step;
                if (r_cnt == w_step) begin
                    w_result_nxt = w_shifted;
                    w_zero_nxt   = (w_shifted == '0);
                    w_state_nxt  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_ctrl   <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_lt     <= 1'b0;
            r_ltu    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_work   <= w_work_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_zero   <= w_zero_nxt;
            r_lt     <= w_lt_nxt;
            r_ltu    <= w_ltu_nxt;
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign busy      = (r_state != StIdle);
    assign result    = r_result;
    assign zero      = r_zero;
    assign lt        = r_lt;
    assign ltu       = r_ltu;

endmodule
